isi_source: RTL and testbench
=============================

Name: isi_source

Overview:
- Per-channel inter-spike-interval (ISI) generator for the landscape-sampling datapath.
- Measures the clock cycles between successive spike events on one channel.
- Presents the interval as a stable ISI word, paired with a comp_addr busy flag.
- Two instances (x and y channels) drive the ISI/comp_addr inputs of the downstream equality comparator. That comparator may only declare a match while both comp_addr flags are low.

Parameters:
- bit_isi, 8: width of the ISI word and of the interval counter.
- SETTLE_CYC, 2: cycles comp_addr stays high after each new capture. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-low; clears all state immediately when low.
- en  input  1  channel enable; low forces IDLE on the next edge.
- spike  input  1  spike event, sampled every cycle; a level held high counts as one spike per cycle.
- isi  output  bit_isi  last captured interval in cycles; never 0 once a capture has occurred.
- comp_addr  output  1  high = isi not valid for comparison (idle, counting first interval, or settling).
- new_isi  output  1  one-cycle pulse in the cycle isi first shows a new capture.

Behaviour:
- Reset values: isi=0, comp_addr=1, new_isi=0, state=IDLE, interval counter cnt=0, settle counter=0.
- All outputs are registered.
- States are IDLE, ARMED, SETTLE and HOLD.
- IDLE: comp_addr=1; cnt held at 0. On spike (with en=1): go to ARMED, cnt<=1, no capture.
- ARMED: comp_addr=1; cnt increments each cycle, saturating at 2^bit_isi-1. On spike: isi<=cnt, cnt<=1, new_isi<=1, settle<=SETTLE_CYC-1, go to SETTLE.
- SETTLE: comp_addr=1; cnt keeps counting.
  - settle==0 and no spike: go to HOLD, comp_addr<=0.
  - Otherwise settle decrements.
  - Spike in SETTLE: recapture exactly as in ARMED, settle reloads and the window restarts; comp_addr stays high.
- HOLD: comp_addr=0; isi stable; cnt counting. On spike: recapture as in ARMED and go to SETTLE (comp_addr<=1 on the same edge).
- Latency:
  - Spike sampled at edge t: isi and new_isi valid from t+1.
  - comp_addr stays high for SETTLE_CYC cycles after t, and is low from cycle t+SETTLE_CYC+1 when no further spike arrives.
- Interval definition: spikes sampled at cycles a and b (b>a) give isi=b-a, saturated to 2^bit_isi-1. Back-to-back spikes give isi=1.
- en=0 in any state: next state IDLE, comp_addr<=1, cnt<=0, new_isi<=0, isi retained. A spike in the same cycle as en=0 is ignored.
- When en returns to 1, the first spike only arms; no capture.
- Asynchronous reset mid-operation (any state): outputs go to reset values immediately. The first spike after release only arms.
- Saturation: cnt never wraps. It holds at 2^bit_isi-1 until a spike or en=0.

Optional Feature:
- Macro: ISI_TIMEOUT_EN.
- Defined:
  - When cnt reaches 2^bit_isi-1 in ARMED, SETTLE or HOLD, the interval is stale.
  - Next edge: state<=IDLE, comp_addr<=1, cnt<=0, isi retained.
  - The following spike only re-arms. Intervals longer than 2^bit_isi-2 cycles are never reported.
- Not defined: saturated intervals are captured as 2^bit_isi-1 and follow the normal SETTLE/HOLD flow.

Test Plan:
- Reset check: drive clr low, then release with spike=0 for 20 cycles -> isi=0, comp_addr=1, new_isi=0 throughout.
- Basic interval (bit_isi=8, SETTLE_CYC=2, en=1): spikes at cycles 10 and 15 -> cycle 16 shows isi=5 and new_isi=1 for one cycle. comp_addr stays 1 through cycle 17 and is 0 from cycle 18. isi holds 5 until the next spike.
- Settle restart: spikes at 10, 15, 16 -> isi=5 at cycle 16 and isi=1 at cycle 17, with new_isi high at both 16 and 17. comp_addr stays 1 through cycle 18 and is 0 at cycle 19.
- Saturation: spikes at 10 and 310 with the macro undefined -> isi=255 at cycle 311, comp_addr 0 from cycle 313. Same stimulus with ISI_TIMEOUT_EN defined -> comp_addr stays 1, no new_isi, isi unchanged; a spike at 320 then 325 gives isi=5.
- Enable drop: steady HOLD with isi=5, deassert en for 1 cycle -> comp_addr=1 next cycle, isi stays 5. After en returns, the first spike does not pulse new_isi; the second does, with the correct interval.
- Async reset mid-SETTLE: pull clr low between edges right after a capture -> isi=0, comp_addr=1, new_isi=0 before the next clock edge.

Source files
------------

// File: rtl/isi_source.sv
// Per-channel inter-spike-interval generator: measures cycles between spikes and flags
// the ISI word busy (comp_addr) while idle, arming or settling. Option: ISI_TIMEOUT_EN.
module isi_source #(
    parameter int unsigned bit_isi    = 8,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic               spike,
    output logic [bit_isi-1:0] isi,
    output logic               comp_addr,
    output logic               new_isi
);

    localparam logic [bit_isi-1:0] CntMax    = {bit_isi{1'b1}};
    localparam logic [bit_isi-1:0] CntOne    = bit_isi'(1);
    localparam logic [3:0]         SettleTop = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StSettle, StHold} state_e;

    state_e             state_q;
    logic [bit_isi-1:0] cnt_q;
    logic [bit_isi-1:0] cnt_inc;
    logic [3:0]         settle_q;
    logic [bit_isi-1:0] isi_q;
    logic               comp_addr_q;
    logic               new_isi_q;

    // Interval counter never wraps; it parks at all-ones.
    always_comb begin
        cnt_inc = cnt_q;
        if (cnt_q != CntMax) begin
            cnt_inc = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            settle_q    <= '0;
            isi_q       <= '0;
            comp_addr_q <= 1'b1;
            new_isi_q   <= 1'b0;
        end else begin
            new_isi_q <= 1'b0;
            if (!en) begin
                state_q     <= StIdle;
                comp_addr_q <= 1'b1;
                cnt_q       <= '0;
`ifdef ISI_TIMEOUT_EN
            end else if (state_q != StIdle && cnt_q == CntMax) begin
                // Stale interval: drop back to idle so it is never reported.
                state_q     <= StIdle;
                comp_addr_q <= 1'b1;
                cnt_q       <= '0;
`endif
            end else if (spike && state_q != StIdle) begin
                isi_q       <= cnt_q;
                cnt_q       <= CntOne;
                new_isi_q   <= 1'b1;
                settle_q    <= SettleTop;
                comp_addr_q <= 1'b1;
                state_q     <= StSettle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        comp_addr_q <= 1'b1;
                        if (spike) begin
                            state_q <= StArmed;
                            cnt_q   <= CntOne;
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    StArmed: begin
                        cnt_q <= cnt_inc;
                    end
                    StSettle: begin
                        cnt_q <= cnt_inc;
                        if (settle_q == 4'd0) begin
                            state_q     <= StHold;
                            comp_addr_q <= 1'b0;
                        end else begin
                            settle_q <= settle_q - 4'd1;
                        end
                    end
                    StHold: begin
                        cnt_q <= cnt_inc;
                    end
                endcase
            end
        end
    end

    assign isi       = isi_q;
    assign comp_addr = comp_addr_q;
    assign new_isi   = new_isi_q;

endmodule

// File: tb/tb_isi_source.sv
// Directed self-checking bench for isi_source (bit_isi=8, SETTLE_CYC=2).
module tb_isi_source;

    logic       clk;
    logic       clr;
    logic       en;
    logic       spike;
    logic [7:0] isi;
    logic       comp_addr;
    logic       new_isi;

    int n_checks;
    int n_errors;

    isi_source #(
        .bit_isi   (8),
        .SETTLE_CYC(2)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .spike    (spike),
        .isi      (isi),
        .comp_addr(comp_addr),
        .new_isi  (new_isi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge with spike driven to s; outputs are sampled 1 time unit later.
    task automatic step(input logic s);
        spike = s;
        @(posedge clk);
        #1;
        spike = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic drop_en;
        en = 1'b0;
        step(1'b0);
        en = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clr      = 1'b0;
        en       = 1'b1;
        spike    = 1'b0;
        #12;
        check("rst_isi", 32'(isi), 0);
        check("rst_comp", 32'(comp_addr), 1);
        check("rst_new", 32'(new_isi), 0);
        clr = 1'b1;

        // Reset hold: no spikes for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            check("quiet_isi", 32'(isi), 0);
            check("quiet_comp", 32'(comp_addr), 1);
            check("quiet_new", 32'(new_isi), 0);
        end

        // Basic interval of 5.
        step(1'b1);
        check("arm_new", 32'(new_isi), 0);
        idle(4);
        step(1'b1);
        check("basic_isi", 32'(isi), 5);
        check("basic_new", 32'(new_isi), 1);
        check("basic_comp_t1", 32'(comp_addr), 1);
        step(1'b0);
        check("basic_new_pulse", 32'(new_isi), 0);
        check("basic_comp_t2", 32'(comp_addr), 1);
        step(1'b0);
        check("basic_comp_t3", 32'(comp_addr), 0);
        idle(3);
        check("basic_hold_isi", 32'(isi), 5);
        check("basic_hold_comp", 32'(comp_addr), 0);

        // Enable drop: a coincident spike is ignored, isi retained.
        en = 1'b0;
        step(1'b1);
        en = 1'b1;
        check("endrop_comp", 32'(comp_addr), 1);
        check("endrop_isi", 32'(isi), 5);
        check("endrop_new", 32'(new_isi), 0);
        step(1'b1);
        check("rearm_new", 32'(new_isi), 0);
        check("rearm_isi", 32'(isi), 5);
        check("rearm_comp", 32'(comp_addr), 1);
        idle(2);
        step(1'b1);
        check("reen_isi", 32'(isi), 3);
        check("reen_new", 32'(new_isi), 1);

        // Settle restart with back-to-back spikes.
        drop_en();
        step(1'b1);
        idle(4);
        step(1'b1);
        check("rs_isi5", 32'(isi), 5);
        check("rs_new5", 32'(new_isi), 1);
        step(1'b1);
        check("rs_isi1", 32'(isi), 1);
        check("rs_new1", 32'(new_isi), 1);
        check("rs_comp_a", 32'(comp_addr), 1);
        step(1'b0);
        check("rs_comp_b", 32'(comp_addr), 1);
        check("rs_new_off", 32'(new_isi), 0);
        step(1'b0);
        check("rs_comp_c", 32'(comp_addr), 0);

        // Saturation: spikes 300 cycles apart.
        drop_en();
        step(1'b1);
        idle(299);
        step(1'b1);
`ifdef ISI_TIMEOUT_EN
        check("to_isi", 32'(isi), 1);
        check("to_new", 32'(new_isi), 0);
        check("to_comp", 32'(comp_addr), 1);
        idle(9);
        step(1'b1);
        idle(4);
        step(1'b1);
        check("to_isi5", 32'(isi), 5);
        check("to_new5", 32'(new_isi), 1);
        idle(2);
        check("to_comp_low", 32'(comp_addr), 0);
`else
        check("sat_isi", 32'(isi), 255);
        check("sat_new", 32'(new_isi), 1);
        check("sat_comp_a", 32'(comp_addr), 1);
        step(1'b0);
        check("sat_comp_b", 32'(comp_addr), 1);
        step(1'b0);
        check("sat_comp_c", 32'(comp_addr), 0);
        check("sat_hold_isi", 32'(isi), 255);
`endif

        // Asynchronous reset right after a capture.
        drop_en();
        step(1'b1);
        idle(1);
        step(1'b1);
        check("ar_pre_isi", 32'(isi), 2);
        #2;
        clr = 1'b0;
        #1;
        check("ar_isi", 32'(isi), 0);
        check("ar_comp", 32'(comp_addr), 1);
        check("ar_new", 32'(new_isi), 0);
        #2;
        clr = 1'b1;
        step(1'b1);
        check("ar_arm_new", 32'(new_isi), 0);
        check("ar_arm_isi", 32'(isi), 0);
        idle(1);
        step(1'b1);
        check("ar_cap_isi", 32'(isi), 2);
        check("ar_cap_new", 32'(new_isi), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
